// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns, COLS_PER_CYCLE columns per clock.
// Ports: clk, rst (sync, active high), in_valid/in_ready/in_data/in_inv,
//   out_valid/out_ready/out_data, busy. Macro MIX_COLUMNS_INV_EN adds inverse.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [127:0] work;
  logic [127:0] nxt;
  logic         mode;
  logic         last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(
    input logic [7:0] b,
    input logic [3:0] c
  );
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & b2) ^
           ({8{c[2]}} & b4) ^ ({8{c[3]}} & b8);
  endfunction

  // Circulant column multiply; row r uses the coefficients rotated by r.
  function automatic logic [31:0] col(
    input logic [31:0] w,
    input logic [3:0]  c0,
    input logic [3:0]  c1,
    input logic [3:0]  c2,
    input logic [3:0]  c3
  );
    logic [7:0] a, b, c, d;
    a = w[31:24];
    b = w[23:16];
    c = w[15:8];
    d = w[7:0];
    return {gm(a, c0) ^ gm(b, c1) ^ gm(c, c2) ^ gm(d, c3),
            gm(a, c3) ^ gm(b, c0) ^ gm(c, c1) ^ gm(d, c2),
            gm(a, c2) ^ gm(b, c3) ^ gm(c, c0) ^ gm(d, c1),
            gm(a, c1) ^ gm(b, c2) ^ gm(c, c3) ^ gm(d, c0)};
  endfunction

  function automatic logic [31:0] col_xf(
    input logic [31:0] w,
    input logic        inv
  );
`ifdef MIX_COLUMNS_INV_EN
    if (inv)
      return col(w, 4'he, 4'hb, 4'hd, 4'h9);
    return col(w, 4'h2, 4'h3, 4'h1, 4'h1);
`else
    logic unused_inv;
    unused_inv = inv;
    return col(w, 4'h2, 4'h3, 4'h1, 4'h1);
`endif
  endfunction

  assign last = (int'(cnt) + COLS_PER_CYCLE) >= 4;

  always_comb begin
    nxt = work;
    for (int c = 0; c < 4; c++) begin
      if (c >= int'(cnt) &&
          c < int'(cnt) + COLS_PER_CYCLE)
        nxt[127-32*c -: 32] =
          col_xf(work[127-32*c -: 32], mode);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      work     <= '0;
      mode     <= 1'b0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
`ifdef MIX_COLUMNS_INV_EN
            mode  <= in_inv;
`else
            mode  <= 1'b0;
`endif
            cnt   <= 2'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          work <= nxt;
          if (last) begin
            out_data <= nxt;
            state    <= DONE;
          end else begin
            cnt <= cnt + 2'(COLS_PER_CYCLE);
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MIX_COLUMNS_INV_EN
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq.
// Instances with COLS_PER_CYCLE 1, 2 and 4 share data inputs.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_ready;
  logic         iv [3];
  logic         ir [3];
  logic         ov [3];
  logic         bz [3];
  logic [127:0] od [3];

  int checks;
  int errors;

  localparam logic [127:0] VA = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] VB = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] VC = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] VD = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_inv(in_inv),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .busy(bz[0])
  );

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_inv(in_inv),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .busy(bz[1])
  );

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data), .in_inv(in_inv),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_txn(
    input  int           k,
    input  logic [127:0] d,
    input  logic         inv,
    output int           lat,
    output logic [127:0] res
  );
    in_data = d;
    in_inv  = inv;
    iv[k]   = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = od[k];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 ||
          bz[k] !== 1'b0 || od[k] !== '0) begin
        errors++;
        $display("FAIL reset k=%0d ir=%b ov=%b bz=%b od=%h want 1 0 0 0",
                 k, ir[k], ov[k], bz[k], od[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    int lat;
    logic [127:0] res;
    int want [3];
    want = '{4, 2, 1};
    for (int k = 0; k < 3; k++) begin
      run_txn(k, VA, 1'b0, lat, res);
      checks++;
      if (res !== VB) begin
        errors++;
        $display("FAIL fwd_data k=%0d got %h want %h", k, res, VB);
      end
      checks++;
      if (lat !== want[k]) begin
        errors++;
        $display("FAIL fwd_lat k=%0d got %0d want %0d", k, lat, want[k]);
      end
    end
  endtask

  task automatic test_inverse();
    int lat;
    logic [127:0] res;
    int want [3];
    want = '{4, 2, 1};
`ifdef MIX_COLUMNS_INV_EN
    for (int k = 0; k < 3; k++) begin
      run_txn(k, VB, 1'b1, lat, res);
      checks++;
      if (res !== VA) begin
        errors++;
        $display("FAIL inv_data k=%0d got %h want %h", k, res, VA);
      end
      checks++;
      if (lat !== want[k]) begin
        errors++;
        $display("FAIL inv_lat k=%0d got %0d want %0d", k, lat, want[k]);
      end
    end
`else
    for (int k = 0; k < 3; k++) begin
      run_txn(k, VA, 1'b1, lat, res);
      checks++;
      if (res !== VB) begin
        errors++;
        $display("FAIL noinv_data k=%0d got %h want %h", k, res, VB);
      end
      checks++;
      if (lat !== want[k]) begin
        errors++;
        $display("FAIL noinv_lat k=%0d got %0d want %0d", k, lat, want[k]);
      end
    end
`endif
  endtask

  task automatic test_corner();
    int lat;
    logic [127:0] res;
    for (int k = 0; k < 3; k += 2) begin
      run_txn(k, VC, 1'b0, lat, res);
      checks++;
      if (res !== VD) begin
        errors++;
        $display("FAIL corner k=%0d got %h want %h", k, res, VD);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    in_data   = VA;
    in_inv    = 1'b0;
    iv[0]     = 1'b1;
    @(posedge clk); #1;
    in_data = VC;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b1 || od[0] !== VB) begin
      errors++;
      $display("FAIL bp_done ov=%b od=%h want 1 %h", ov[0], od[0], VB);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== VB || ir[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold i=%0d ov=%b ir=%b od=%h want 1 0 %h",
                 i, ov[0], ir[0], od[0], VB);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== VB) begin
      errors++;
      $display("FAIL bp_idle ov=%b ir=%b od=%h want 0 1 %h",
               ov[0], ir[0], od[0], VB);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    checks++;
    if (bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept2 busy=%b want 1", bz[0]);
    end
    n = 0;
    while (!ov[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (od[0] !== VD || ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_second ov=%b got %h want %h", ov[0], od[0], VD);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [127:0] res;
    in_data = VA;
    in_inv  = 1'b0;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || od[0] !== '0 ||
        ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid ov=%b od=%h ir=%b bz=%b want 0 0 1 0",
               ov[0], od[0], ir[0], bz[0]);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ov[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_nooutput got %0d valid cycles want 0", seen);
    end
    run_txn(0, VA, 1'b0, lat, res);
    checks++;
    if (res !== VB || lat !== 4) begin
      errors++;
      $display("FAIL rst_after got %h lat %0d want %h lat 4",
               res, lat, VB);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_corner();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
